// File: rtl/i2s_tx_10xe_axi4_lite_slave.sv
// AXI4-Lite control-port slave and register file for the I2S transmitter.
// AW and W are buffered independently; the write commits once both are held.
// Out-of-range accesses return SLVERR; writes to read-only registers are dropped.
// Optional build macro: AXI_LITE_STRB_EN (adds s_axi_ctrl_wstrb byte-lane enables).
module i2s_tx_10xe_axi4_lite_slave #(
    parameter int unsigned          ADDR_W   = 8,
    parameter int unsigned          DATA_W   = 32,
    parameter int unsigned          NUM_REGS = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK  = '0,
    parameter logic [DATA_W-1:0]    RST_VAL  = '0
) (
    input  logic                         s_axi_ctrl_aclk,
    input  logic                         s_axi_ctrl_aresetn,
    input  logic [ADDR_W-1:0]            s_axi_ctrl_awaddr,
    input  logic                         s_axi_ctrl_awvalid,
    output logic                         s_axi_ctrl_awready,
    input  logic [DATA_W-1:0]            s_axi_ctrl_wdata,
`ifdef AXI_LITE_STRB_EN
    input  logic [DATA_W/8-1:0]          s_axi_ctrl_wstrb,
`endif
    input  logic                         s_axi_ctrl_wvalid,
    output logic                         s_axi_ctrl_wready,
    output logic [1:0]                   s_axi_ctrl_bresp,
    output logic                         s_axi_ctrl_bvalid,
    input  logic                         s_axi_ctrl_bready,
    input  logic [ADDR_W-1:0]            s_axi_ctrl_araddr,
    input  logic                         s_axi_ctrl_arvalid,
    output logic                         s_axi_ctrl_arready,
    output logic [DATA_W-1:0]            s_axi_ctrl_rdata,
    output logic [1:0]                   s_axi_ctrl_rresp,
    output logic                         s_axi_ctrl_rvalid,
    input  logic                         s_axi_ctrl_rready,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic [NUM_REGS-1:0]          reg_wr,
    input  logic [NUM_REGS*DATA_W-1:0]   status_i
);
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LSB    = $clog2(STRB_W);
    localparam int unsigned IDX_W  = ADDR_W - LSB;

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t wstate, wstate_nx;
    rstate_t rstate, rstate_nx;

    logic              aw_full, w_full;
    logic [IDX_W-1:0]  aw_idx, ar_idx;
    logic [DATA_W-1:0] w_data;
`ifdef AXI_LITE_STRB_EN
    logic [STRB_W-1:0] w_strb;
`endif
    logic [DATA_W-1:0] regs [NUM_REGS];

    logic              aw_hs, w_hs, commit, b_hs, ar_hs, r_hs;
    logic              w_in_range, r_in_range;
    logic [NUM_REGS-1:0] w_sel;
    logic [DATA_W-1:0] wr_mask, r_val;
    logic              unused_addr_bits;

    // Low byte-offset bits of both addresses do not select a register.
    assign unused_addr_bits = ^{s_axi_ctrl_awaddr, s_axi_ctrl_araddr};
    assign ar_idx = s_axi_ctrl_araddr[ADDR_W-1:LSB];

    // Decode buffered write target, byte-lane mask and read source.
    always_comb begin
        w_in_range = (32'(aw_idx) < NUM_REGS);
        r_in_range = (32'(ar_idx) < NUM_REGS);
        w_sel      = '0;
        r_val      = '0;
        wr_mask    = '1;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(aw_idx) == i && !RO_MASK[i])
                w_sel[i] = 1'b1;
            if (32'(ar_idx) == i)
                r_val = RO_MASK[i] ? status_i[i*DATA_W +: DATA_W] : regs[i];
        end
`ifdef AXI_LITE_STRB_EN
        for (int unsigned b = 0; b < STRB_W; b++)
            wr_mask[b*8 +: 8] = {8{w_strb[b]}};
`endif
    end

    // Flatten the register array onto reg_q.
    always_comb begin
        reg_q = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++)
            reg_q[i*DATA_W +: DATA_W] = regs[i];
    end

    // Write FSM next state and handshake decode.
    always_comb begin
        wstate_nx = wstate;
        aw_hs     = s_axi_ctrl_awvalid && s_axi_ctrl_awready;
        w_hs      = s_axi_ctrl_wvalid && s_axi_ctrl_wready;
        commit    = 1'b0;
        b_hs      = 1'b0;
        case (wstate)
            W_COLLECT: if (aw_full && w_full) begin
                commit    = 1'b1;
                wstate_nx = W_RESP;
            end
            W_RESP: if (s_axi_ctrl_bvalid && s_axi_ctrl_bready) begin
                b_hs      = 1'b1;
                wstate_nx = W_COLLECT;
            end
            default: wstate_nx = W_COLLECT;
        endcase
    end

    // Read FSM next state and handshake decode.
    always_comb begin
        rstate_nx = rstate;
        ar_hs     = s_axi_ctrl_arvalid && s_axi_ctrl_arready;
        r_hs      = s_axi_ctrl_rvalid && s_axi_ctrl_rready;
        case (rstate)
            R_IDLE:  if (ar_hs) rstate_nx = R_DATA;
            R_DATA:  if (r_hs)  rstate_nx = R_IDLE;
            default: rstate_nx = R_IDLE;
        endcase
    end

    // FSM state registers.
    always_ff @(posedge s_axi_ctrl_aclk) begin
        if (!s_axi_ctrl_aresetn) begin
            wstate <= W_COLLECT;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_nx;
            rstate <= rstate_nx;
        end
    end

    // Write channel buffers, register commit and B response.
    always_ff @(posedge s_axi_ctrl_aclk) begin
        if (!s_axi_ctrl_aresetn) begin
            aw_full            <= 1'b0;
            w_full             <= 1'b0;
            aw_idx             <= '0;
            w_data             <= '0;
`ifdef AXI_LITE_STRB_EN
            w_strb             <= '0;
`endif
            s_axi_ctrl_awready <= 1'b0;
            s_axi_ctrl_wready  <= 1'b0;
            s_axi_ctrl_bvalid  <= 1'b0;
            s_axi_ctrl_bresp   <= '0;
            reg_wr             <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++)
                regs[i] <= RST_VAL;
        end else begin
            reg_wr <= '0;
            if (aw_hs) begin
                aw_full            <= 1'b1;
                aw_idx             <= s_axi_ctrl_awaddr[ADDR_W-1:LSB];
                s_axi_ctrl_awready <= 1'b0;
            end else if (wstate == W_COLLECT && !aw_full) begin
                s_axi_ctrl_awready <= 1'b1;
            end
            if (w_hs) begin
                w_full            <= 1'b1;
                w_data            <= s_axi_ctrl_wdata;
`ifdef AXI_LITE_STRB_EN
                w_strb            <= s_axi_ctrl_wstrb;
`endif
                s_axi_ctrl_wready <= 1'b0;
            end else if (wstate == W_COLLECT && !w_full) begin
                s_axi_ctrl_wready <= 1'b1;
            end
            if (commit) begin
                s_axi_ctrl_bvalid <= 1'b1;
                s_axi_ctrl_bresp  <= w_in_range ? 2'b00 : 2'b10;
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    if (w_sel[i]) begin
                        regs[i]   <= (regs[i] & ~wr_mask) | (w_data & wr_mask);
                        reg_wr[i] <= 1'b1;
                    end
                end
            end
            if (b_hs) begin
                s_axi_ctrl_bvalid  <= 1'b0;
                aw_full            <= 1'b0;
                w_full             <= 1'b0;
                s_axi_ctrl_awready <= 1'b1;
                s_axi_ctrl_wready  <= 1'b1;
            end
        end
    end

    // Read channel: capture data in the AR handshake cycle, hold until rready.
    always_ff @(posedge s_axi_ctrl_aclk) begin
        if (!s_axi_ctrl_aresetn) begin
            s_axi_ctrl_arready <= 1'b0;
            s_axi_ctrl_rvalid  <= 1'b0;
            s_axi_ctrl_rdata   <= '0;
            s_axi_ctrl_rresp   <= '0;
        end else begin
            if (ar_hs) begin
                s_axi_ctrl_rvalid  <= 1'b1;
                s_axi_ctrl_arready <= 1'b0;
                s_axi_ctrl_rdata   <= r_in_range ? r_val : '0;
                s_axi_ctrl_rresp   <= r_in_range ? 2'b00 : 2'b10;
            end else if (rstate == R_IDLE) begin
                s_axi_ctrl_arready <= 1'b1;
            end
            if (r_hs) begin
                s_axi_ctrl_rvalid  <= 1'b0;
                s_axi_ctrl_arready <= 1'b1;
            end
        end
    end
endmodule

// File: doc/i2s_tx_10xe_axi4_lite_slave.md
Name: i2s_tx_10xe_axi4_lite_slave

Overview:
- Parametrised AXI4-Lite control-port slave and register file for the I2S transmitter. Generalises the fixed 8-bit-address / 32-bit-data control interface.
- Address width, data width, register count and read-only map are all configurable.
- AW and W channels are independently buffered. Out-of-range accesses return SLVERR.
- Sits between the testbench/SoC AXI4-Lite master and the I2S TX core. Exposes register contents and write pulses to the core.

Parameters:
- ADDR_W, 8: byte-address width. Must be >= 2 + clog2(NUM_REGS).
- DATA_W, 32: data width. Must be a multiple of 8.
- NUM_REGS, 8: number of word registers, mapped at byte offsets 0, DATA_W/8, ...
- RO_MASK, {NUM_REGS{1'b0}}: bit i=1 makes register i read-only; it reads status_i slice i.
- RST_VAL, 0: reset value of every writable register.

Ports:
- s_axi_ctrl_aclk  in  1  clock
- s_axi_ctrl_aresetn  in  1  synchronous active-low reset
- s_axi_ctrl_awaddr  in  ADDR_W  write address
- s_axi_ctrl_awvalid  in  1  write address valid
- s_axi_ctrl_awready  out  1  write address ready
- s_axi_ctrl_wdata  in  DATA_W  write data
- s_axi_ctrl_wstrb  in  DATA_W/8  byte strobes (only present with AXI_LITE_STRB_EN)
- s_axi_ctrl_wvalid  in  1  write data valid
- s_axi_ctrl_wready  out  1  write data ready
- s_axi_ctrl_bresp  out  2  write response (00 OKAY, 10 SLVERR)
- s_axi_ctrl_bvalid  out  1  write response valid
- s_axi_ctrl_bready  in  1  write response ready
- s_axi_ctrl_araddr  in  ADDR_W  read address
- s_axi_ctrl_arvalid  in  1  read address valid
- s_axi_ctrl_arready  out  1  read address ready
- s_axi_ctrl_rdata  out  DATA_W  read data
- s_axi_ctrl_rresp  out  2  read response
- s_axi_ctrl_rvalid  out  1  read data valid
- s_axi_ctrl_rready  in  1  read data ready
- reg_q  out  NUM_REGS*DATA_W  flat register contents; register i at [i*DATA_W +: DATA_W]
- reg_wr  out  NUM_REGS  one-cycle pulse when register i is written
- status_i  in  NUM_REGS*DATA_W  readback source for RO registers

Behaviour:
- Reset, sampled on the clock edge while aresetn=0:
  - All ready/valid outputs are 0; bresp, rresp and rdata are 0.
  - reg_q = RST_VAL; reg_wr = 0.
  - awready, wready and arready rise on the first edge after reset deasserts.
- Reset mid-transaction aborts the transaction: pending AW/W/B/R state is cleared and no register is updated.
- Register index is addr[ADDR_W-1:log2(DATA_W/8)]. Low address bits are ignored.
- Index >= NUM_REGS is out of range.
- Write FSM, states W_COLLECT and W_RESP:
  - In W_COLLECT, AW and W each latch into a one-entry buffer on handshake, in either order or the same cycle.
  - awready drops the edge after the AW handshake; wready drops the edge after the W handshake.
  - On the edge following the cycle in which both buffers are full: commit the write, pulse reg_wr[i], assert bvalid, enter W_RESP.
  - bvalid holds until bready. On the B handshake edge, clear the buffers, raise awready/wready and return to W_COLLECT.
  - Minimum throughput: one write per 3 cycles.
- Write response codes:
  - Out of range: no update, no reg_wr pulse, bresp=SLVERR.
  - RO register target: no update, no reg_wr pulse, bresp=OKAY.
  - Otherwise bresp=OKAY.
- Read FSM, states R_IDLE and R_DATA:
  - AR handshake in R_IDLE. Next edge: rdata/rresp registered, rvalid=1, arready=0, enter R_DATA.
  - rdata = reg_q slice, or status_i slice for RO registers, sampled in the AR handshake cycle.
  - Out of range: rdata=0, rresp=SLVERR.
  - rvalid and rdata hold stable until rready. On the handshake edge, rvalid=0, arready=1, return to R_IDLE.
- Read and write channels are fully independent.
- Same-cycle AR handshake and write commit to the same register: the read returns the pre-write value.
- Valid outputs never drop without the matching ready; data is stable while valid is high.

Optional Feature:
- Macro AXI_LITE_STRB_EN.
- Defined: s_axi_ctrl_wstrb port exists; only byte lanes with strobe=1 are updated. reg_wr pulses even if wstrb=0.
- Undefined: port absent; every write updates the full word.

Test Plan:
- Reset, then read all NUM_REGS=8 registers -> rdata=RST_VAL (0), rresp=OKAY, rvalid one cycle after each AR handshake.
- AW addr 0x04 handshaken 3 cycles before W data 0xDEADBEEF -> reg_q[63:32]=0xDEADBEEF; reg_wr=8'b0000_0010 for one cycle; bvalid the edge after W, bresp=OKAY.
- Write 0x11223344 to 0x08 with bready held low 5 cycles -> bvalid stays high, awready/wready stay low; a second AW is not accepted until the B handshake.
- Write and read 0x40 (index 16, out of range) -> bresp=SLVERR with no reg_wr; rdata=0, rresp=SLVERR.
- RO_MASK=8'h01, status_i[31:0]=0xCAFE0001; write 0x0 to 0x00 -> bresp OKAY, no update; read 0x00 -> 0xCAFE0001.
- With AXI_LITE_STRB_EN, reg 3=0xFFFFFFFF; write 0x00000000 with wstrb=4'b0101 -> reg 3 reads 0xFF00FF00.
